// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - round-robin two-master arbiter for the 5-bit/8-bit register bus
module reg_bus_arbiter #(
    parameter int                ADDR_W      = 5,
    parameter int                DATA_W      = 8,
    parameter int                TIMEOUT_CYC = 255,
    parameter logic [DATA_W-1:0] ERR_DATA    = 8'hEE
) (
    input  logic              osc_clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    // Last WAIT count before the transaction is aborted; counter starts at 0 in the first WAIT cycle
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                last_q, last_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                bus_rd_q, bus_rd_d;
    logic                bus_wr_q, bus_wr_d;
    logic                pick;

    // On a tie the master that did not win last time is chosen; a lone request always wins
    assign pick = (req0 && req1) ? ~last_q : req1;

    // Next-state and registered-output computation for the whole transaction sequence
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata_d  = '0;
        err_d    = 1'b0;
        bus_rd_d = 1'b0;
        bus_wr_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    gnt_d    = pick;
                    we_d     = pick ? we1 : we0;
                    addr_d   = pick ? addr1 : addr0;
                    wdata_d  = pick ? wdata1 : wdata0;
                    bus_rd_d = ~(pick ? we1 : we0);
                    bus_wr_d = pick ? we1 : we0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus_ready) begin
                    rdata_d = we_q ? '0 : bus_rdata;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                last_d  = gnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset clears everything and lets master 0 win the first tie
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= 8'd0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            bus_rd_q <= 1'b0;
            bus_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            bus_rd_q <= bus_rd_d;
            bus_wr_q <= bus_wr_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign bus_rd    = bus_rd_q;
    assign bus_wr    = bus_wr_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - self-checking bench for reg_bus_arbiter (two instances: long and short timeout)
module tb_reg_bus_arbiter;

    localparam int TMO0 = 255;
    localparam int TMO1 = 4;

    logic       osc_clk = 1'b0;
    logic       rst_n;
    logic       req0[2], req1[2], we0[2], we1[2];
    logic [4:0] addr0[2], addr1[2];
    logic [7:0] wdata0[2], wdata1[2];
    logic       ack0[2], ack1[2], err[2], busy[2], bus_rd[2], bus_wr[2];
    logic [7:0] rdata[2], bus_wdata[2], bus_rdata[2];
    logic [4:0] bus_addr[2];
    logic       bus_ready[2];

    int checks = 0;
    int failures = 0;

    // slave responder controls: dly = WAIT cycles with ready low before ready (-1 = never)
    int         dly[2];
    int         wcnt[2];
    logic [7:0] rd_val[2];

    always #5 osc_clk = ~osc_clk;

    reg_bus_arbiter #(.TIMEOUT_CYC(TMO0)) dut0 (
        .osc_clk(osc_clk), .rst_n(rst_n),
        .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
        .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
        .ack0(ack0[0]), .ack1(ack1[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0]),
        .bus_rd(bus_rd[0]), .bus_wr(bus_wr[0]), .bus_addr(bus_addr[0]), .bus_wdata(bus_wdata[0]),
        .bus_rdata(bus_rdata[0]), .bus_ready(bus_ready[0])
    );

    reg_bus_arbiter #(.TIMEOUT_CYC(TMO1)) dut1 (
        .osc_clk(osc_clk), .rst_n(rst_n),
        .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
        .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
        .ack0(ack0[1]), .ack1(ack1[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1]),
        .bus_rd(bus_rd[1]), .bus_wr(bus_wr[1]), .bus_addr(bus_addr[1]), .bus_wdata(bus_wdata[1]),
        .bus_rdata(bus_rdata[1]), .bus_ready(bus_ready[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Slave: ready asserted after dly[k] WAIT cycles; ready is also driven high outside WAIT
    // whenever the slave is slow, which the arbiter must ignore
    always @(negedge osc_clk) begin
        for (int k = 0; k < 2; k++) begin
            if (bus_rd[k] || bus_wr[k]) begin
                wcnt[k] = 0;
                bus_ready[k] = (dly[k] > 0);
            end else if (busy[k] && !ack0[k] && !ack1[k]) begin
                bus_ready[k] = (dly[k] >= 0 && wcnt[k] >= dly[k]);
                wcnt[k]++;
            end else begin
                bus_ready[k] = (dly[k] > 0);
            end
            bus_rdata[k] = rd_val[k];
        end
    end

    // Transaction-level model: a granted transaction has an age in cycles since its grant;
    // ready counts from age 2 on (the WAIT cycles), timeout after TMO WAIT cycles
    bit         m_act[2], m_done[2], m_g[2], m_we[2], m_last[2];
    int         m_age[2];
    logic [4:0] m_addr[2];
    logic [7:0] m_wd[2];
    logic       e_ack0[2], e_ack1[2], e_rd[2], e_wr[2], e_err[2];
    logic [7:0] e_rdata[2];

    always @(posedge osc_clk) begin
        for (int k = 0; k < 2; k++) begin
            e_ack0[k] = 0; e_ack1[k] = 0; e_rd[k] = 0; e_wr[k] = 0; e_err[k] = 0; e_rdata[k] = 0;
            if (!rst_n) begin
                m_act[k] = 0; m_done[k] = 0; m_g[k] = 0; m_we[k] = 0; m_last[k] = 1;
                m_age[k] = 0; m_addr[k] = 0; m_wd[k] = 0;
            end else if (m_done[k]) begin
                m_act[k] = 0; m_done[k] = 0; m_last[k] = m_g[k];
            end else if (m_act[k]) begin
                m_age[k]++;
                if (m_age[k] >= 2) begin
                    if (bus_ready[k]) begin
                        m_done[k] = 1;
                        e_rdata[k] = m_we[k] ? 8'h00 : bus_rdata[k];
                    end else if (m_age[k] - 1 == (k == 0 ? TMO0 : TMO1)) begin
                        m_done[k] = 1;
                        e_rdata[k] = 8'hEE;
                        e_err[k] = 1;
                    end
                    if (m_done[k]) begin
                        e_ack0[k] = !m_g[k];
                        e_ack1[k] = m_g[k];
                    end
                end
            end else if (req0[k] || req1[k]) begin
                m_g[k] = (req0[k] && req1[k]) ? !m_last[k] : req1[k];
                m_we[k] = m_g[k] ? we1[k] : we0[k];
                m_addr[k] = m_g[k] ? addr1[k] : addr0[k];
                m_wd[k] = m_g[k] ? wdata1[k] : wdata0[k];
                m_act[k] = 1; m_age[k] = 0;
                e_rd[k] = !m_we[k];
                e_wr[k] = m_we[k];
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("m%0d_busy", k), busy[k], m_act[k]);
            chk($sformatf("m%0d_bus_rd", k), bus_rd[k], e_rd[k]);
            chk($sformatf("m%0d_bus_wr", k), bus_wr[k], e_wr[k]);
            chk($sformatf("m%0d_ack0", k), ack0[k], e_ack0[k]);
            chk($sformatf("m%0d_ack1", k), ack1[k], e_ack1[k]);
            chk($sformatf("m%0d_bus_addr", k), bus_addr[k], m_addr[k]);
            chk($sformatf("m%0d_bus_wdata", k), bus_wdata[k], m_wd[k]);
            if (e_ack0[k] || e_ack1[k]) begin
                chk($sformatf("m%0d_rdata", k), rdata[k], e_rdata[k]);
                chk($sformatf("m%0d_err", k), err[k], e_err[k]);
            end
        end
    end

    task automatic clear_inputs(input int k);
        req0[k] = 0; req1[k] = 0; we0[k] = 0; we1[k] = 0;
        addr0[k] = 0; addr1[k] = 0; wdata0[k] = 0; wdata1[k] = 0;
    endtask

    // One transaction from master r on instance k; lat = posedges from the sampling edge to ack
    task automatic txn(input int k, input bit r, input bit we, input logic [4:0] a, input logic [7:0] wd,
                       input int d, input logic [7:0] rv, input int exp_lat, input logic [7:0] exp_rd,
                       input bit exp_err, input bit drop, input string nm);
        int lat, nstrb;
        bit got;
        @(negedge osc_clk);
        dly[k] = d; rd_val[k] = rv;
        if (r) begin req1[k] = 1; we1[k] = we; addr1[k] = a; wdata1[k] = wd; end
        else   begin req0[k] = 1; we0[k] = we; addr0[k] = a; wdata0[k] = wd; end
        lat = 0; nstrb = 0; got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge osc_clk); #2;
            lat++;
            if (bus_rd[k] || bus_wr[k]) nstrb++;
            if (lat == 1) begin
                chk({nm, "_strobe_rd"}, bus_rd[k], !we);
                chk({nm, "_strobe_wr"}, bus_wr[k], we);
                // post-grant input changes must not reach the bus
                if (r) begin we1[k] = !we; addr1[k] = ~a; wdata1[k] = ~wd; if (drop) req1[k] = 0; end
                else   begin we0[k] = !we; addr0[k] = ~a; wdata0[k] = ~wd; if (drop) req0[k] = 0; end
            end
            chk({nm, "_addr_stable"}, bus_addr[k], a);
            chk({nm, "_wdata_stable"}, bus_wdata[k], wd);
            if (r ? ack1[k] : ack0[k]) got = 1;
        end
        chk({nm, "_acked"}, got, 1);
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_rdata"}, rdata[k], exp_rd);
        chk({nm, "_err"}, err[k], exp_err);
        chk({nm, "_strobes"}, nstrb, 1);
        @(negedge osc_clk);
        clear_inputs(k);
    endtask

    initial begin
        int seq[4];
        int nack, lat;
        bit got;
        rst_n = 0;
        for (int k = 0; k < 2; k++) begin
            clear_inputs(k); dly[k] = 0; wcnt[k] = 0; rd_val[k] = 0;
        end
        repeat (3) @(posedge osc_clk);
        #2;
        chk("reset_busy", busy[0], 0);
        chk("reset_ack0", ack0[0], 0);
        chk("reset_bus_rd", bus_rd[0], 0);
        chk("reset_bus_addr", bus_addr[0], 0);
        @(negedge osc_clk);
        rst_n = 1;

        // both masters from reset, held: grants must alternate 0,1,0,1
        @(negedge osc_clk);
        dly[0] = 0; rd_val[0] = 8'h11;
        req0[0] = 1; req1[0] = 1; addr0[0] = 5'h01; addr1[0] = 5'h09;
        nack = 0;
        for (int i = 0; i < 40 && nack < 4; i++) begin
            @(posedge osc_clk); #2;
            chk("rr_no_double_ack", ack0[0] && ack1[0], 0);
            if (ack0[0] || ack1[0]) begin
                seq[nack] = ack1[0] ? 1 : 0;
                nack++;
            end
        end
        chk("rr_ack_count", nack, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), seq[i], i % 2);
        @(negedge osc_clk);
        clear_inputs(0);

        // minimum-latency read
        txn(0, 0, 0, 5'h02, 8'h00, 0, 8'hA5, 3, 8'hA5, 0, 0, "t1_read");
        // write from master 1, four slow WAIT cycles, req dropped right after grant
        txn(0, 1, 1, 5'h05, 8'h3C, 4, 8'h77, 7, 8'h00, 0, 1, "t2_write");
        // short-timeout instance: dead slave, then healthy slave
        txn(1, 0, 0, 5'h0A, 8'h00, -1, 8'h55, 6, 8'hEE, 1, 0, "t4_timeout");
        txn(1, 0, 0, 5'h0A, 8'h00, 0, 8'h55, 3, 8'h55, 0, 0, "t4_recover");
        // one WAIT short of the timeout still completes normally
        txn(1, 1, 0, 5'h13, 8'h00, 3, 8'h6B, 6, 8'h6B, 0, 0, "t4_edge");

        // asynchronous reset during WAIT
        @(negedge osc_clk);
        dly[0] = -1; req0[0] = 1; addr0[0] = 5'h1F; wdata0[0] = 8'h81;
        repeat (4) @(posedge osc_clk);
        #2;
        chk("t5_busy_before", busy[0], 1);
        #1;
        rst_n = 0;
        #1;
        chk("t5_async_busy", busy[0], 0);
        chk("t5_async_addr", bus_addr[0], 0);
        chk("t5_async_wdata", bus_wdata[0], 0);
        chk("t5_async_ack", {ack0[0], ack1[0]}, 0);
        chk("t5_async_strobe", {bus_rd[0], bus_wr[0]}, 0);
        chk("t5_async_rdata_err", {rdata[0], err[0]}, 0);
        clear_inputs(0);
        dly[0] = 0;
        repeat (2) @(posedge osc_clk);
        @(negedge osc_clk);
        rst_n = 1;
        req0[0] = 1; req1[0] = 1; addr0[0] = 5'h03; addr1[0] = 5'h04;
        got = 0; lat = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge osc_clk); #2;
            lat++;
            if (ack0[0] || ack1[0]) got = 1;
        end
        chk("t5_first_acked", got, 1);
        chk("t5_first_is_req0", {ack0[0], ack1[0]}, 2'b10);
        chk("t5_first_latency", lat, 3);
        @(negedge osc_clk);
        req0[0] = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge osc_clk); #2;
            chk("t5_no_ack0_again", ack0[0], 0);
            if (ack1[0]) got = 1;
        end
        chk("t5_second_is_req1", got, 1);
        @(negedge osc_clk);
        clear_inputs(0);

        repeat (4) @(posedge osc_clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
